i2c_byte_master: RTL and testbench

- Avalon-MM slave I2C byte-level master for the on-board RTC bus; replaces software bit-banging of the SCL/SDA PIO bits.
- Software loads a byte, the divider and a command word. The block sequences START, 8 data bits plus ACK, and STOP on open-drain SCL/SDA, with clock-stretching support.
- Sits between the HPS/Nios bridge and the top-level SCL/SDA tri-state pads.

---
 rtl/i2c_byte_master.sv | 195 +++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Avalon-MM I2C byte master: START, 8 data bits + ACK, STOP on open-drain SCL/SDA.
// Each phase is four quarters of D clocks; SCL stretching holds the FSM at the end of q1.
module i2c_byte_master #(
  parameter int DEFAULT_DIV = 125,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       q, q_nxt;
  logic [3:0]       bit_cnt, bit_nxt;
  logic [DIV_W-1:0] div, cnt, d_eff;
  logic [7:0]       tx, rx;
  logic             done, rx_ack, busy;
  logic             c_stop, c_write, c_read, c_ack;
  logic             scl_m, scl_s, sda_m, sda_s;
  logic             wr, cmd_wr, launch, q_end, advance, finish, enter, nbit;
  logic             scl_nxt, sda_nxt;
  logic             unused_wdata;

  assign busy         = (state != ST_IDLE);
  assign wr           = chipselect && !write_n && !busy;
  assign cmd_wr       = wr && (address == 2'd1);
  assign launch       = cmd_wr && (|writedata[3:0]);
  assign d_eff        = (div == '0) ? DIV_W'(1) : div;
  assign q_end        = busy && (cnt == d_eff - DIV_W'(1));
  // A slave holding SCL low at the end of q1 freezes both the divider and the FSM.
  assign advance      = q_end && !((q == 2'd1) && !scl_s);
  assign unused_wdata = ^writedata[31:DIV_W];

  function automatic state_t after_start(input logic w, input logic r, input logic s);
    if (w) return ST_WRITE;
    if (r) return ST_READ;
    if (s) return ST_STOP;
    return ST_IDLE;
  endfunction

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    bit_nxt   = bit_cnt;
    enter     = 1'b0;
    finish    = 1'b0;
    if (!busy) begin
      if (launch) begin
        state_nxt = writedata[0] ? ST_START
                                 : after_start(writedata[2], writedata[3], writedata[1]);
        q_nxt     = 2'd0;
        bit_nxt   = 4'd0;
        enter     = 1'b1;
      end
    end else if (advance) begin
      q_nxt = q + 2'd1;
      if (q == 2'd3) begin
        case (state)
          ST_START: state_nxt = after_start(c_write, c_read, c_stop);
          ST_WRITE, ST_READ: begin
            if (bit_cnt != 4'd8) begin
              bit_nxt = bit_cnt + 4'd1;
            end else begin
              bit_nxt   = 4'd0;
              state_nxt = c_stop ? ST_STOP : ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
      finish = (state_nxt == ST_IDLE);
      enter  = !finish;
    end

    // Bit value driven in the phase being entered; the 9th bit releases SDA on writes.
    nbit = 1'b1;
    if (state_nxt == ST_WRITE && bit_nxt != 4'd8) nbit = tx[3'd7 - bit_nxt[2:0]];
    if (state_nxt == ST_READ && bit_nxt == 4'd8)  nbit = c_ack;

    scl_nxt = scl_oe;
    sda_nxt = sda_oe;
    if (enter) begin
      case (state_nxt)
        ST_START: begin
          case (q_nxt)
            2'd0:    sda_nxt = 1'b0;
            2'd1:    scl_nxt = 1'b0;
            2'd2:    sda_nxt = 1'b1;
            default: scl_nxt = 1'b1;
          endcase
        end
        ST_WRITE, ST_READ: begin
          case (q_nxt)
            2'd0: begin
              scl_nxt = 1'b1;
              sda_nxt = !nbit;
            end
            2'd1:    scl_nxt = 1'b0;
            2'd3:    scl_nxt = 1'b1;
            default: ;
          endcase
        end
        ST_STOP: begin
          case (q_nxt)
            2'd0: begin
              scl_nxt = 1'b1;
              sda_nxt = 1'b1;
            end
            2'd1:    scl_nxt = 1'b0;
            2'd2:    sda_nxt = 1'b0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      q       <= 2'd0;
      bit_cnt <= 4'd0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      bit_cnt <= bit_nxt;
      scl_oe  <= scl_nxt;
      sda_oe  <= sda_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_m   <= 1'b1;
      scl_s   <= 1'b1;
      sda_m   <= 1'b1;
      sda_s   <= 1'b1;
      cnt     <= '0;
      tx      <= 8'h00;
      rx      <= 8'h00;
      div     <= DIV_W'(DEFAULT_DIV);
      done    <= 1'b0;
      rx_ack  <= 1'b0;
      c_stop  <= 1'b0;
      c_write <= 1'b0;
      c_read  <= 1'b0;
      c_ack   <= 1'b0;
    end else begin
      scl_m <= scl_in;
      scl_s <= scl_m;
      sda_m <= sda_in;
      sda_s <= sda_m;
      if (!busy || advance) cnt <= '0;
      else if (!q_end)      cnt <= cnt + DIV_W'(1);
      if (wr && address == 2'd0) tx  <= writedata[7:0];
      if (wr && address == 2'd2) div <= writedata[DIV_W-1:0];
      if (cmd_wr) done <= 1'b0;
      if (launch) {c_ack, c_read, c_write, c_stop} <= writedata[4:1];
      if (finish) done <= 1'b1;
      // SDA is sampled on the last clock of q2, while SCL is high.
      if (advance && q == 2'd2 && state == ST_WRITE && bit_cnt == 4'd8) rx_ack <= sda_s;
      if (advance && q == 2'd2 && state == ST_READ && bit_cnt != 4'd8)  rx <= {rx[6:0], sda_s};
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0:    readdata = {24'h0, rx};
      2'd1:    readdata = {29'h0, done, rx_ack, busy};
      2'd2:    readdata = 32'(div);
      default: readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: register table, then transfers against a simple open-drain slave.
module tb_i2c_byte_master;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [31:0] readdata;
  logic        scl_in, sda_in, scl_oe, sda_oe;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Slave / pad model state.
  logic [8:0] slave_pat   = 9'h1FF;
  int         slave_idx   = -1;
  int         slave_start = -1;
  int         cmd_seq     = 0;
  logic       hold        = 1'b0;
  int         hold_cnt    = 0;
  logic       stretch_arm = 1'b0;
  logic       stretch_err = 1'b0;
  logic       rd_chk      = 1'b0;
  logic       rd_err      = 1'b0;
  logic       stop_seen   = 1'b0;
  logic       rec_en      = 1'b0;
  int         rise_extra  = 0;
  logic [0:0] exp_q[$];
  logic       slave_sda;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  i2c_byte_master #(.DEFAULT_DIV(125), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  assign slave_sda = (slave_idx >= 0 && slave_idx <= 8) ? slave_pat[4'd8 - slave_idx[3:0]] : 1'b1;
  assign scl_in    = !scl_oe && !hold;
  assign sda_in    = !sda_oe && slave_sda;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_idle(input int c0, input int budget, output int dur);
    address = 2'd1;
    #1;
    for (int i = 0; i < budget && readdata[0]; i++) @(negedge clk);
    check("busy_cleared_in_budget", 32'(readdata[0]), 32'd0);
    dur = cyc - c0;
  endtask

  // Pad monitor and slave: SCL falls step the slave's bit index, SCL rises check SDA.
  task automatic monitor();
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    logic p_scl_oe = 1'b0;
    logic s_scl, s_sda, e;
    int   seen = 0;
    forever begin
      @(negedge clk);
      s_scl = scl_in;
      s_sda = sda_in;
      if (cmd_seq != seen) begin
        seen      = cmd_seq;
        slave_idx = slave_start;
      end
      if (!p_scl_oe && scl_oe) slave_idx++;
      if (rec_en && !p_scl && s_scl) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sda_at_scl_rise", 32'(s_sda), 32'(e));
        end else begin
          rise_extra++;
        end
      end
      if (!p_sda && s_sda && p_scl && s_scl) stop_seen = 1'b1;
      if (rd_chk && slave_idx <= 8 && sda_oe) rd_err = 1'b1;
      if (stretch_arm && p_scl_oe && !scl_oe) begin
        hold        = 1'b1;
        hold_cnt    = 50;
        stretch_arm = 1'b0;
      end else if (hold) begin
        if (scl_oe) stretch_err = 1'b1;
        hold_cnt--;
        if (hold_cnt == 0) hold = 1'b0;
      end
      p_scl    = s_scl;
      p_sda    = s_sda;
      p_scl_oe = scl_oe;
    end
  endtask

  task automatic push_write_pattern(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int c0, dur;
    fork
      monitor();
    join_none

    vecs[0]  = '{1'b0, 2'd2, 32'h0,          32'd125};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,          32'h0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,          32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,          32'h0};
    vecs[4]  = '{1'b1, 2'd3, 32'hFFFF_FFFF,  32'h0};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,          32'h0};
    vecs[6]  = '{1'b1, 2'd2, 32'h0001_2345,  32'h0};
    vecs[7]  = '{1'b0, 2'd2, 32'h0,          32'h2345};
    vecs[8]  = '{1'b1, 2'd0, 32'h0000_01A5,  32'h0};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,          32'h0};
    vecs[10] = '{1'b1, 2'd2, 32'h0,          32'h0};
    vecs[11] = '{1'b0, 2'd2, 32'h0,          32'h0};
    vecs[12] = '{1'b1, 2'd1, 32'h0,          32'h0};
    vecs[13] = '{1'b0, 2'd1, 32'h0,          32'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_scl_oe", 32'(scl_oe), 32'd0);
    check("reset_sda_oe", 32'(sda_oe), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        @(negedge clk);
        bus_read(vecs[i].addr, rd);
        check($sformatf("table_%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // div=0 behaves as D=1: START-only takes 4 clocks and leaves both lines low.
    cmd_seq++;
    bus_write(2'd1, 32'h01);
    c0 = cyc;
    wait_idle(c0, 100, dur);
    check("start_only_div0_busy", 32'(dur), 32'd4);
    bus_read(2'd1, rd);
    check("start_only_status", rd, 32'h4);
    check("start_only_scl_oe", 32'(scl_oe), 32'd1);
    check("start_only_sda_oe", 32'(sda_oe), 32'd1);

    // STOP-only at D=4 releases both lines.
    bus_write(2'd2, 32'd4);
    cmd_seq++;
    bus_write(2'd1, 32'h02);
    c0 = cyc;
    wait_idle(c0, 200, dur);
    check("stop_only_busy", 32'(dur), 32'd16);
    check("stop_only_scl_oe", 32'(scl_oe), 32'd0);
    check("stop_only_sda_oe", 32'(sda_oe), 32'd0);

    // START + WRITE 0xA5 + STOP, slave ACKs.
    bus_write(2'd0, 32'hA5);
    slave_pat   = {8'hFF, 1'b0};
    slave_start = -1;
    push_write_pattern(8'hA5);
    rec_en = 1'b1;
    cmd_seq++;
    bus_write(2'd1, 32'h07);
    c0 = cyc;
    wait_idle(c0, 1000, dur);
    rec_en = 1'b0;
    check("write_busy_cycles", 32'(dur), 32'd176);
    check("write_exp_q_drained", 32'(exp_q.size()), 32'd0);
    bus_read(2'd1, rd);
    check("write_status", rd, 32'h4);

    // READ + STOP with NACK, slave sends 0x3C.
    slave_pat = {8'h3C, 1'b1};
    stop_seen = 1'b0;
    rd_err    = 1'b0;
    rd_chk    = 1'b1;
    cmd_seq++;
    bus_write(2'd1, 32'h1A);
    c0 = cyc;
    wait_idle(c0, 1000, dur);
    rd_chk = 1'b0;
    check("read_busy_cycles", 32'(dur), 32'd160);
    bus_read(2'd0, rd);
    check("read_rx", rd, 32'h3C);
    check("read_sda_released_thru_ack", 32'(rd_err), 32'd0);
    check("read_stop_seen", 32'(stop_seen), 32'd1);
    bus_read(2'd1, rd);
    check("read_status", rd, 32'h4);

    // START + WRITE with slave stretching SCL for 50 clocks from bit-0 q1.
    slave_pat   = {8'hFF, 1'b0};
    stretch_arm = 1'b1;
    stretch_err = 1'b0;
    cmd_seq++;
    bus_write(2'd1, 32'h05);
    c0 = cyc;
    wait_idle(c0, 1000, dur);
    check("stretch_busy_207_to_209", 32'(dur >= 207 && dur <= 209), 32'd1);
    check("stretch_no_scl_drive_while_held", 32'(stretch_err), 32'd0);
    check("stretch_hold_released", 32'(hold), 32'd0);
    check("no_stop_scl_held_low", 32'(scl_oe), 32'd1);
    check("no_stop_sda_released", 32'(sda_oe), 32'd0);

    // WRITE + STOP from SCL low; writes issued while busy must be ignored.
    slave_start = 0;
    push_write_pattern(8'hA5);
    rec_en = 1'b1;
    cmd_seq++;
    bus_write(2'd1, 32'h06);
    c0 = cyc;
    bus_write(2'd0, 32'hFF);
    bus_write(2'd2, 32'd9);
    bus_write(2'd1, 32'h01);
    wait_idle(c0, 1000, dur);
    rec_en = 1'b0;
    check("busy_writes_ignored_cycles", 32'(dur), 32'd160);
    check("busy_writes_exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("no_extra_scl_rises", 32'(rise_extra), 32'd0);
    bus_read(2'd2, rd);
    check("busy_div_unchanged", rd, 32'd4);
    bus_read(2'd1, rd);
    check("busy_done_after", rd, 32'h4);
    bus_write(2'd1, 32'h00);
    bus_read(2'd1, rd);
    check("cmd0_clears_done", rd, 32'h0);
    repeat (3) @(negedge clk);
    bus_read(2'd1, rd);
    check("cmd0_stays_idle", rd, 32'h0);

    // Reset during bit 3 of a write.
    slave_start = -1;
    cmd_seq++;
    bus_write(2'd1, 32'h07);
    repeat (69) @(negedge clk);
    bus_read(2'd1, rd);
    check("midxfer_busy", 32'(rd[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midxfer_reset_scl_oe", 32'(scl_oe), 32'd0);
    check("midxfer_reset_sda_oe", 32'(sda_oe), 32'd0);
    bus_read(2'd1, rd);
    check("midxfer_reset_status", rd, 32'h0);
    bus_read(2'd2, rd);
    check("midxfer_reset_div", rd, 32'd125);
    bus_read(2'd0, rd);
    check("midxfer_reset_rx", rd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
